// File: rtl/pc_sequencer.sv
// pc_sequencer: front-end PC control, fetch-miss tracking and redirect arbitration
// Inputs: clk, reset (async, active-high), hazard_stall, mispredict/mispredict_pc,
//   id_jump/id_jump_target, halt, imem_ack.
// Outputs: imem_req, stall, stall_pc, bubble/pc_recovered, jump/jump_target,
//   flush_if, flush_id, halted; with PC_PERF_CNT_EN defined also redirect_count, miss_cycles.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        mispredict,
  input  logic [15:0] mispredict_pc,
  input  logic        id_jump,
  input  logic [15:0] id_jump_target,
  input  logic        halt,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        stall,
  output logic        stall_pc,
  output logic        bubble,
  output logic [15:0] pc_recovered,
  output logic        jump,
  output logic [15:0] jump_target,
  output logic        flush_if,
  output logic        flush_id,
  output logic        halted
`ifdef PC_PERF_CNT_EN
  ,
  output logic [15:0] redirect_count,
  output logic [15:0] miss_cycles
`endif
);
  localparam logic [1:0] RUN = 2'd0, MISS = 2'd1, HALT = 2'd2;
  localparam logic [1:0] NONE = 2'd0, JUMP = 2'd1, RECOVER = 2'd2;
  logic [1:0] state, state_nx, pend_kind, pend_kind_nx, eff_kind;
  logic [15:0] pend_pc, pend_pc_nx, eff_pc;
  logic new_jump;
  // pending entry as it stands after this cycle's requests: a mispredict
  // overwrites anything, a jump only fills an empty slot
  assign new_jump = id_jump && !hazard_stall && pend_kind == NONE;
  assign eff_kind = mispredict ? RECOVER : new_jump ? JUMP : pend_kind;
  assign eff_pc = mispredict ? mispredict_pc : new_jump ? id_jump_target : pend_pc;
  always_comb begin
    imem_req = 1'b0;
    stall = 1'b0;
    stall_pc = 1'b0;
    bubble = 1'b0;
    pc_recovered = RESET_PC;
    jump = 1'b0;
    jump_target = 16'h0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    halted = 1'b0;
    state_nx = state;
    pend_kind_nx = pend_kind;
    pend_pc_nx = pend_pc;
    if (state == HALT) begin
      stall = 1'b1;
      halted = 1'b1;
    end else if (halt) begin
      stall = 1'b1;
      state_nx = HALT;
      pend_kind_nx = NONE;
      pend_pc_nx = 16'h0;
    end else if (state == RUN) begin
      imem_req = 1'b1;
      if (mispredict) begin
        bubble = 1'b1;
        pc_recovered = mispredict_pc;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (hazard_stall) begin
        stall = 1'b1;
      end else if (id_jump && imem_ack) begin
        jump = 1'b1;
        jump_target = id_jump_target;
        flush_if = 1'b1;
      end else if (id_jump) begin
        pend_kind_nx = JUMP;
        pend_pc_nx = id_jump_target;
        stall_pc = 1'b1;
        flush_if = 1'b1;
        state_nx = MISS;
      end else if (!imem_ack) begin
        stall_pc = 1'b1;
        state_nx = MISS;
      end
    end else begin
      imem_req = 1'b1;
      stall = hazard_stall;
      flush_id = mispredict;
      if (imem_ack) begin
        bubble = eff_kind == RECOVER;
        jump = eff_kind == JUMP;
        pc_recovered = eff_kind == RECOVER ? eff_pc : RESET_PC;
        jump_target = eff_kind == JUMP ? eff_pc : 16'h0;
        flush_if = eff_kind != NONE;
        state_nx = RUN;
        pend_kind_nx = NONE;
        pend_pc_nx = 16'h0;
      end else begin
        stall_pc = 1'b1;
        pend_kind_nx = eff_kind;
        pend_pc_nx = eff_pc;
      end
    end
    if (reset) begin
      imem_req = 1'b0;
      stall = 1'b0;
      stall_pc = 1'b0;
      bubble = 1'b0;
      pc_recovered = RESET_PC;
      jump = 1'b0;
      jump_target = 16'h0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      halted = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pend_kind <= NONE;
      pend_pc <= 16'h0;
    end else begin
      state <= state_nx;
      pend_kind <= pend_kind_nx;
      pend_pc <= pend_pc_nx;
    end
  end
`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_count <= 16'h0;
      miss_cycles <= 16'h0;
    end else begin
      if ((bubble || jump) && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
      if (state == MISS && miss_cycles != 16'hFFFF) miss_cycles <= miss_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer against a queue-based redirect model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, hazard_stall = 1'b0, mispredict = 1'b0, id_jump = 1'b0, halt = 1'b0, imem_ack = 1'b0;
  logic [15:0] mispredict_pc = '0, id_jump_target = '0;
  logic imem_req, stall, stall_pc, bubble, jump, flush_if, flush_id, halted;
  logic [15:0] pc_recovered, jump_target, redirect_count, miss_cycles;
  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .mispredict(mispredict),
    .mispredict_pc(mispredict_pc), .id_jump(id_jump), .id_jump_target(id_jump_target),
    .halt(halt), .imem_ack(imem_ack), .imem_req(imem_req), .stall(stall), .stall_pc(stall_pc),
    .bubble(bubble), .pc_recovered(pc_recovered), .jump(jump), .jump_target(jump_target),
    .flush_if(flush_if), .flush_id(flush_id), .halted(halted)
`ifdef PC_PERF_CNT_EN
    , .redirect_count(redirect_count), .miss_cycles(miss_cycles)
`endif
  );
`ifndef PC_PERF_CNT_EN
  assign redirect_count = '0;
  assign miss_cycles = '0;
`endif

  typedef struct packed {
    logic imem_req, stall, stall_pc, bubble;
    logic [15:0] pc_recovered;
    logic jump;
    logic [15:0] jump_target;
    logic flush_if, flush_id, halted;
    logic [15:0] rc, mc;
  } exp_t;
  typedef struct packed {bit rec; logic [15:0] pc;} red_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0;

  bit m_halted, m_waiting;
  red_t rq[$];
  logic [15:0] m_rc, m_mc;

  task automatic model_reset();
    m_halted = 0;
    m_waiting = 0;
    rq.delete();
    m_rc = 0;
    m_mc = 0;
  endtask

  task automatic drive(input bit r, input bit h, input bit mp, input logic [15:0] mpc,
                       input bit hz, input bit j, input logic [15:0] jt, input bit ack);
    exp_t e;
    bit was_waiting;
    @(posedge clk);
    #1;
    reset = r; halt = h; mispredict = mp; mispredict_pc = mpc;
    hazard_stall = hz; id_jump = j; id_jump_target = jt; imem_ack = ack;
    e = '0;
    e.pc_recovered = 16'hFFFF;
    if (r) begin
      model_reset();
      sb.push_back(e);
      return;
    end
    e.rc = m_rc;
    e.mc = m_mc;
    was_waiting = m_waiting;
    if (m_halted) begin
      e.stall = 1; e.halted = 1;
    end else if (h) begin
      e.stall = 1;
      m_halted = 1; m_waiting = 0; rq.delete();
    end else if (!m_waiting) begin
      e.imem_req = 1;
      if (mp) begin
        e.bubble = 1; e.pc_recovered = mpc; e.flush_if = 1; e.flush_id = 1;
      end else if (hz) e.stall = 1;
      else if (j) begin
        e.flush_if = 1;
        if (ack) begin e.jump = 1; e.jump_target = jt; end
        else begin e.stall_pc = 1; rq.push_back('{rec: 0, pc: jt}); m_waiting = 1; end
      end else if (!ack) begin
        e.stall_pc = 1; m_waiting = 1;
      end
    end else begin
      e.imem_req = 1; e.stall = hz; e.flush_id = mp;
      if (mp) begin rq.delete(); rq.push_back('{rec: 1, pc: mpc}); end
      else if (j && !hz && rq.size() == 0) rq.push_back('{rec: 0, pc: jt});
      if (ack) begin
        if (rq.size() != 0) begin
          e.flush_if = 1;
          if (rq[0].rec) begin e.bubble = 1; e.pc_recovered = rq[0].pc; end
          else begin e.jump = 1; e.jump_target = rq[0].pc; end
        end
        rq.delete();
        m_waiting = 0;
      end else e.stall_pc = 1;
    end
    if ((e.bubble || e.jump) && m_rc != 16'hFFFF) m_rc++;
    if (was_waiting && m_mc != 16'hFFFF) m_mc++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {imem_req, stall, stall_pc, bubble, pc_recovered, jump, jump_target,
           flush_if, flush_id, halted, redirect_count, miss_cycles};
`ifndef PC_PERF_CNT_EN
      e.rc = '0;
      e.mc = '0;
`endif
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs vector %0d: got %h required %h", vectors, a, e);
      end
    end
  end

  task automatic idle(input bit ack);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, ack);
  endtask

  initial begin
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    repeat (4) idle(1);
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0040, 1);
    idle(0);
    idle(0);
    drive(0, 0, 1, 16'h0123, 0, 0, 16'h0, 0);
    idle(0);
    idle(1);
    idle(1);
    idle(0);
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0200, 0);
    drive(0, 0, 1, 16'h0300, 0, 0, 16'h0, 0);
    idle(1);
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0500, 0);
    drive(0, 0, 0, 16'h0, 0, 1, 16'h0600, 0);
    idle(1);
    drive(0, 0, 0, 16'h0, 1, 1, 16'h0700, 1);
    idle(0);
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    idle(1);
    drive(0, 1, 1, 16'h0999, 0, 0, 16'h0, 1);
    repeat (3) idle(1);
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            16'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            16'($urandom), $urandom_range(0, 1) == 0);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
